calc_ctrl: RTL and testbench
============================

# calc_ctrl

Keypad-driven sequencer and display scanner for the 4-bit calculator datapath.
- Accepts single-cycle key events and builds operand A, operator and operand B.
- Drives the calculator's `num1`/`num2`/`select` inputs from registers.
- Time-multiplexes the calculator's four 7-segment outputs onto one shared segment bus with one-hot digit enables.
- Sits between the keypad front end (debounced, one pulse per press) and the board display; the calculator instance stays purely combinational.

## Interface
Parameters:
- `SCAN_DIV`, 1024: clock cycles each digit stays enabled; legal range ≥2.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid while it is high.
- `key_code`  in  4  0–9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQUALS, 15 CLEAR.
- `num1`  out  4  operand A to calculator.
- `num2`  out  4  operand B to calculator.
- `select`  out  4  one-hot operator to calculator; 0 while no result is requested.
- `seg_n1`, `seg_n2`, `seg_h`, `seg_l`  in  8 each  segment patterns from calculator; active-high segments.
- `seg_out`  out  8  shared segment bus, active-high.
- `dig_en`  out  4  one-hot digit enable: [3] n1, [2] n2, [1] h, [0] l.
- `state_o`  out  3  current FSM state, for debug/LED.

## Operation
FSM states and transitions. Events are digit, op, EQ and CLR. Any key not listed for a state is ignored with no change.
- IDLE:
  - digit → A=digit, go to GOT_A.
- GOT_A:
  - digit → A=digit (replace).
  - op → latch op, go to GOT_OP.
- GOT_OP:
  - op → replace the latched op.
  - digit → B=digit, go to GOT_B.
- GOT_B:
  - digit → B=digit (replace).
  - EQ → go to SHOW.
- SHOW:
  - digit → A=digit, B=0, go to GOT_A.
  - op and EQ are ignored.
- CLR in any state → IDLE with A=0, B=0 and op=ADD.

Output rules:
- `select` = one-hot op only in SHOW; 4'b0000 otherwise.
- `num1`=A and `num2`=B at all times.
- `state_o` encoding: IDLE 0, GOT_A 1, GOT_OP 2, GOT_B 3, SHOW 4.

Display blanking (blank = `seg_out` 8'h00):
- Digit n1 is blanked in IDLE.
- Digit n2 is blanked in IDLE, GOT_A and GOT_OP.
- Digits h and l are blanked in every state except SHOW.

Scanner:
- Counter runs 0..SCAN_DIV-1.
- On wrap to 0, `dig_en` rotates right: 1000→0100→0010→0001→1000.
- The scanner runs free and is independent of the FSM.

## Timing
Reset values (asserted asynchronously when `rst_n`=0):
- FSM in IDLE, A=0, B=0, op=ADD.
- `num1`=0, `num2`=0, `select`=0, `state_o`=0.
- `dig_en`=4'b1000, scan counter 0, `seg_out`=8'h00.
- Release is sampled at the first rising edge with `rst_n`=1.

Latency and ordering:
- A key sampled at edge k updates the state, `num1`/`num2`/`select` and `state_o` after edge k; all of these are registered.
- `seg_out` is registered. Each cycle it captures the pattern selected by the current `dig_en` (the value before that edge's rotation) under the current blanking rule. It therefore lags `dig_en` and state changes by one cycle.
- `key_valid` held high for N cycles counts as N key events. The front end guarantees single pulses.
- Reset asserted mid-operation aborts immediately. There is no pending event after release.
- Key event coincident with a scanner wrap: both take effect at the same edge, independently.

## Structure
- Shared package `calc_pkg`:
  - key-code constants: `KEY_ADD`..`KEY_CLR`.
  - one-hot select constants: `SEL_ADD`=0001, `SEL_SUB`=0010, `SEL_MUL`=0100, `SEL_DIV`=1000.
  - FSM state encoding.
- One sub-module, `disp_scan`: scan counter, `dig_en` rotation and registered 4:1 segment mux with per-digit blank inputs.
- The FSM and operand registers live in the top level.

## Test plan
- Reset, then run 4×`SCAN_DIV` cycles idle → `dig_en` cycles 1000,0100,0010,0001; `seg_out`=0 throughout; `num1`=`num2`=`select`=0.
- Keys 7, ADD, 5, EQ → `num1`=7, `num2`=5, `select`=0001 one cycle after EQ; `state_o`=4; digit h/l slots carry `seg_h`/`seg_l` unblanked.
- Keys 3, 4, SUB, MUL, 2, EQ → `num1`=4, `num2`=2, `select`=0100; both replacements take effect.
- EQ in IDLE, op in GOT_A after GOT_A's op, digit then EQ in GOT_A → the ignored keys cause no state change. Specifically, EQ in GOT_A keeps `state_o`=1 and `select`=0.
- From SHOW press 9 → `num1`=9, `num2`=0, `select`=0, `state_o`=1. Then CLR → all zero, `state_o`=0.
- Assert `rst_n` low for one cycle while in GOT_B → outputs return to reset values asynchronously; the next key 6 lands in GOT_A with `num1`=6.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, operator selects and FSM encoding for calc_ctrl
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [3:0] SEL_ADD = 4'b0001;
  localparam logic [3:0] SEL_SUB = 4'b0010;
  localparam logic [3:0] SEL_MUL = 4'b0100;
  localparam logic [3:0] SEL_DIV = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_GOT_OP = 3'd2,
    ST_GOT_B  = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic logic [3:0] op_to_sel(input logic [3:0] k);
    case (k)
      KEY_SUB: return SEL_SUB;
      KEY_MUL: return SEL_MUL;
      KEY_DIV: return SEL_DIV;
      default: return SEL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - free-running digit scanner with registered, blankable segment mux
module disp_scan #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_n1,
  input  logic [7:0] seg_n2,
  input  logic [7:0] seg_h,
  input  logic [7:0] seg_l,
  input  logic [3:0] blank,
  output logic [3:0] dig_en,
  output logic [7:0] seg_out
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [7:0]    seg_sel;

  // blank bits share the dig_en bit positions: [3] n1, [2] n2, [1] h, [0] l
  always_comb begin
    seg_sel = 8'h00;
    case (dig_en)
      4'b1000: seg_sel = blank[3] ? 8'h00 : seg_n1;
      4'b0100: seg_sel = blank[2] ? 8'h00 : seg_n2;
      4'b0010: seg_sel = blank[1] ? 8'h00 : seg_h;
      4'b0001: seg_sel = blank[0] ? 8'h00 : seg_l;
      default: seg_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dig_en  <= 4'b1000;
      seg_out <= 8'h00;
    end else begin
      seg_out <= seg_sel;
      if (cnt == CNT_MAX) begin
        cnt    <= '0;
        dig_en <= {dig_en[0], dig_en[3:1]};
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - keypad sequencer driving the calculator operands and display scan
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] select,
  input  logic [7:0] seg_n1,
  input  logic [7:0] seg_n2,
  input  logic [7:0] seg_h,
  input  logic [7:0] seg_l,
  output logic [7:0] seg_out,
  output logic [3:0] dig_en,
  output logic [2:0] state_o
);

  state_t     state;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] op_sel;
  logic [3:0] blank;

  assign num1    = a_q;
  assign num2    = b_q;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      op_sel <= SEL_ADD;
      select <= 4'b0000;
    end else if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state  <= ST_IDLE;
        a_q    <= 4'd0;
        b_q    <= 4'd0;
        op_sel <= SEL_ADD;
        select <= 4'b0000;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_digit(key_code)) begin
              a_q   <= key_code;
              state <= ST_GOT_A;
            end
          end
          ST_GOT_A: begin
            if (is_digit(key_code)) begin
              a_q <= key_code;
            end else if (is_op(key_code)) begin
              op_sel <= op_to_sel(key_code);
              state  <= ST_GOT_OP;
            end
          end
          ST_GOT_OP: begin
            if (is_op(key_code)) begin
              op_sel <= op_to_sel(key_code);
            end else if (is_digit(key_code)) begin
              b_q   <= key_code;
              state <= ST_GOT_B;
            end
          end
          ST_GOT_B: begin
            if (is_digit(key_code)) begin
              b_q <= key_code;
            end else if (key_code == KEY_EQ) begin
              select <= op_sel;
              state  <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            // a new digit starts a fresh calculation; operators and EQ are dead here
            if (is_digit(key_code)) begin
              a_q    <= key_code;
              b_q    <= 4'd0;
              select <= 4'b0000;
              state  <= ST_GOT_A;
            end
          end
          default: begin
            state  <= ST_IDLE;
            select <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign blank[3] = (state == ST_IDLE);
  assign blank[2] = (state == ST_IDLE) || (state == ST_GOT_A) || (state == ST_GOT_OP);
  assign blank[1] = (state != ST_SHOW);
  assign blank[0] = (state != ST_SHOW);

  disp_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_disp_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_n1  (seg_n1),
    .seg_n2  (seg_n2),
    .seg_h   (seg_h),
    .seg_l   (seg_l),
    .blank   (blank),
    .dig_en  (dig_en),
    .seg_out (seg_out)
  );

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - directed self-checking bench for calc_ctrl
module tb_calc_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] num1, num2, select, dig_en;
  logic [7:0] seg_out;
  logic [2:0] state_o;
  logic [7:0] seg_n1 = 8'h11;
  logic [7:0] seg_n2 = 8'h22;
  logic [7:0] seg_h  = 8'h44;
  logic [7:0] seg_l  = 8'h88;

  int n_tests = 0;
  int n_fail  = 0;

  calc_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .num1      (num1),
    .num2      (num2),
    .select    (select),
    .seg_n1    (seg_n1),
    .seg_n2    (seg_n2),
    .seg_h     (seg_h),
    .seg_l     (seg_l),
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] es, input logic [2:0] est);
    check({tag, "_num1"},   num1,    e1);
    check({tag, "_num2"},   num2,    e2);
    check({tag, "_select"}, select,  es);
    check({tag, "_state"},  state_o, est);
  endtask

  // wait (bounded) for a digit slot, then check what the next edge latches onto seg_out
  task automatic check_slot(input string tag, input logic [3:0] d, input logic [7:0] exp);
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      if (dig_en == d) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_slot"}, dig_en, d);
    @(posedge clk);
    #1;
    check({tag, "_seg"}, seg_out, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_outs("reset", 4'd0, 4'd0, 4'b0000, 3'd0);
    check("reset_dig_en", dig_en, 4'b1000);
    check("reset_seg", seg_out, 8'h00);

    // idle scan: each digit held SCAN_DIV edges, all blanked
    for (int e = 1; e <= 4 * SCAN_DIV; e++) begin
      logic [3:0] exp_en;
      @(posedge clk);
      #1;
      case ((e / SCAN_DIV) % 4)
        0: exp_en = 4'b1000;
        1: exp_en = 4'b0100;
        2: exp_en = 4'b0010;
        default: exp_en = 4'b0001;
      endcase
      check($sformatf("scan_en_%0d", e), dig_en, exp_en);
      check($sformatf("scan_seg_%0d", e), seg_out, 8'h00);
    end
    check_outs("idle", 4'd0, 4'd0, 4'b0000, 3'd0);

    // 7 + 5 =
    press(4'd7);
    check_outs("got_a7", 4'd7, 4'd0, 4'b0000, 3'd1);
    check_slot("got_a_n2_blank", 4'b0100, 8'h00);
    check_slot("got_a_n1_shown", 4'b1000, 8'h11);
    press(4'd10);
    press(4'd5);
    check_outs("got_b5", 4'd7, 4'd5, 4'b0000, 3'd3);
    press(4'd14);
    check_outs("show_add", 4'd7, 4'd5, 4'b0001, 3'd4);
    check_slot("show_h", 4'b0010, 8'h44);
    check_slot("show_l", 4'b0001, 8'h88);
    check_slot("show_n2", 4'b0100, 8'h22);

    // replacements: 3 4 SUB MUL 2 =
    press(4'd3);
    check_outs("show_to_a3", 4'd3, 4'd0, 4'b0000, 3'd1);
    press(4'd4);
    press(4'd11);
    press(4'd12);
    check_outs("got_op_mul", 4'd4, 4'd0, 4'b0000, 3'd2);
    press(4'd2);
    press(4'd14);
    check_outs("show_mul", 4'd4, 4'd2, 4'b0100, 3'd4);

    // ignored keys
    press(4'd15);
    press(4'd14);
    check_outs("eq_in_idle", 4'd0, 4'd0, 4'b0000, 3'd0);
    press(4'd1);
    press(4'd14);
    check_outs("eq_in_got_a", 4'd1, 4'd0, 4'b0000, 3'd1);
    press(4'd10);
    press(4'd14);
    check_outs("eq_in_got_op", 4'd1, 4'd0, 4'b0000, 3'd2);
    press(4'd3);
    press(4'd8);
    press(4'd11);
    check_outs("op_in_got_b", 4'd1, 4'd8, 4'b0000, 3'd3);
    press(4'd14);
    press(4'd12);
    press(4'd14);
    check_outs("op_eq_in_show", 4'd1, 4'd8, 4'b0001, 3'd4);

    // new digit from SHOW, then CLR
    press(4'd9);
    check_outs("show_to_a9", 4'd9, 4'd0, 4'b0000, 3'd1);
    press(4'd15);
    check_outs("clr", 4'd0, 4'd0, 4'b0000, 3'd0);

    // asynchronous reset while in GOT_B
    press(4'd5);
    press(4'd11);
    press(4'd3);
    check_outs("pre_rst", 4'd5, 4'd3, 4'b0000, 3'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_outs("async_rst", 4'd0, 4'd0, 4'b0000, 3'd0);
    check("async_rst_dig_en", dig_en, 4'b1000);
    check("async_rst_seg", seg_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    press(4'd6);
    check_outs("post_rst_a6", 4'd6, 4'd0, 4'b0000, 3'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
